// File: rtl/mem_pkg.sv
// Shared types and defaults for the wait-state memory responder.
// Holds the FSM encoding, default geometry and byte-lane count.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  localparam int DEF_DEPTH       = 64;
  localparam int DEF_WAIT_CYCLES = 2;
  localparam int NUM_LANES       = 4;

endpackage

// File: rtl/mem_array.sv
// Word storage with per-byte write enables.
// Writes land on the rising edge; reads are combinational.
module mem_array
  import mem_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [NUM_LANES-1:0] be,
  input  logic [AW-1:0]        addr,
  input  logic [31:0]          wdata,
  output logic [31:0]          rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int k = 0; k < NUM_LANES; k++) begin
        if (be[k]) begin
          mem[addr][8*k +: 8] <= wdata[8*k +: 8];
        end
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory target with a fixed number of wait states.
// Captures a request, waits, then acks for one cycle with data or error.
module mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH       = DEF_DEPTH,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic        i_clk_w,
  input  logic        i_rst_w,
  input  logic        i_req_w,
  input  logic        i_we_w,
  input  logic [31:0] i_addr_w,
  input  logic [31:0] i_wdata_w,
  input  logic [3:0]  i_be_w,
  output logic        o_ack_w,
  output logic [31:0] o_rdata_w,
  output logic        o_err_w,
  output logic        o_busy_w
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT =
    (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t               state;
  logic [3:0]           cnt;
  logic                 we_q;
  logic                 err_q;
  logic [AW-1:0]        idx_q;
  logic [31:0]          wdata_q;
  logic [NUM_LANES-1:0] be_q;

  logic        addr_err;
  logic        ack;
  logic        wr_en;
  logic [31:0] mem_rdata;

  assign addr_err = (|i_addr_w[1:0]) | (|i_addr_w[31:AW+2]);

  always_ff @(posedge i_clk_w) begin
    if (!i_rst_w) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (i_req_w) begin
            we_q    <= i_we_w;
            idx_q   <= i_addr_w[AW+1:2];
            wdata_q <= i_wdata_w;
            be_q    <= i_be_w;
            err_q   <= addr_err;
            cnt     <= CNT_INIT;
            state   <= (WAIT_CYCLES == 0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign ack = (state == RESP);

  // Gate with reset so a reset landing on the RESP edge drops the write.
  assign wr_en = ack & we_q & ~err_q & i_rst_w;

  mem_array #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_mem (
    .clk  (i_clk_w),
    .we   (wr_en),
    .be   (be_q),
    .addr (idx_q),
    .wdata(wdata_q),
    .rdata(mem_rdata)
  );

  assign o_ack_w   = ack;
  assign o_err_w   = ack & err_q;
  assign o_busy_w  = (state != IDLE);
  assign o_rdata_w = (ack & ~err_q & ~we_q) ? mem_rdata : 32'd0;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench: random and directed traffic against an array model,
// plus a short directed pass on a zero-wait-state instance.
module tb_mem_responder;
  import mem_pkg::*;

  localparam int W = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  be = '0;
  logic        ack, err, busy;
  logic [31:0] rdata;

  logic        req0 = 1'b0;
  logic        we0 = 1'b0;
  logic [31:0] addr0 = '0;
  logic [31:0] wdata0 = '0;
  logic [3:0]  be0 = '0;
  logic        ack0, err0, busy0;
  logic [31:0] rdata0;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  logic mon_en = 1'b0;

  logic [31:0] model [64];

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  exp_t q[$];
  exp_t m;

  mem_responder #(.DEPTH(64), .WAIT_CYCLES(W)) dut (
    .i_clk_w  (clk),
    .i_rst_w  (rst_n),
    .i_req_w  (req),
    .i_we_w   (we),
    .i_addr_w (addr),
    .i_wdata_w(wdata),
    .i_be_w   (be),
    .o_ack_w  (ack),
    .o_rdata_w(rdata),
    .o_err_w  (err),
    .o_busy_w (busy)
  );

  mem_responder #(.DEPTH(64), .WAIT_CYCLES(0)) dut0 (
    .i_clk_w  (clk),
    .i_rst_w  (rst_n),
    .i_req_w  (req0),
    .i_we_w   (we0),
    .i_addr_w (addr0),
    .i_wdata_w(wdata0),
    .i_be_w   (be0),
    .o_ack_w  (ack0),
    .o_rdata_w(rdata0),
    .o_err_w  (err0),
    .o_busy_w (busy0)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)",
               name, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (ack) begin
        if (q.size() == 0) begin
          check("unexpected_ack", 32'(ack), 32'd0);
        end else begin
          m = q.pop_front();
          check("ack_cycle", cyc, m.due);
          check("err", 32'(err), 32'(m.err));
          check("rdata", rdata, m.rdata);
        end
      end else begin
        check("quiet_out", rdata | 32'(err), 32'd0);
      end
      if (q.size() > 0 && cyc > q[0].due) begin
        check("missed_ack", cyc, q[0].due);
        void'(q.pop_front());
      end
    end
  end

  task automatic do_txn(input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] b,
                        input bit hold, input bit abort);
    int   n = 0;
    exp_t e;
    @(negedge clk);
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("idle_timeout", 32'(busy), 32'd0);
    req   = 1'b1;
    we    = w;
    addr  = a;
    wdata = d;
    be    = b;
    if (!abort) begin
      e.err   = (a[1:0] != 2'd0) || (a[31:8] != 24'd0);
      e.rdata = (e.err || w) ? 32'd0 : model[a[7:2]];
      e.due   = cyc + 1 + W;
      q.push_back(e);
      if (w && !e.err) begin
        for (int k = 0; k < 4; k++) begin
          if (b[k]) model[a[7:2]][8*k +: 8] = d[8*k +: 8];
        end
      end
    end
    @(posedge clk);
    #1;
    if (!hold) req = 1'b0;
    we    = ~w;
    addr  = $urandom;
    wdata = $urandom;
    be    = 4'($urandom);
    @(negedge clk);
    check("busy_after_accept", 32'(busy), 32'd1);
  endtask

  logic [31:0] ra;
  logic [31:0] d0;
  int          r;

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out", rdata | 32'(err), 32'd0);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    for (int i = 0; i < 64; i++) begin
      do_txn(1'b1, 32'(i) << 2, $urandom, 4'hF, 1'b0, 1'b0);
    end

    do_txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0);
    do_txn(1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 1'b0);

    do_txn(1'b1, 32'h20, 32'h11223344, 4'hF, 1'b0, 1'b0);
    do_txn(1'b1, 32'h20, 32'hAABBCCDD, 4'h5, 1'b0, 1'b0);
    do_txn(1'b0, 32'h20, 32'h0, 4'h0, 1'b0, 1'b0);

    do_txn(1'b0, 32'h13, 32'h0, 4'h0, 1'b0, 1'b0);
    do_txn(1'b0, 32'h100, 32'h0, 4'h0, 1'b0, 1'b0);
    do_txn(1'b1, 32'h100, 32'hFFFFFFFF, 4'hF, 1'b0, 1'b0);
    do_txn(1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 1'b0);

    do_txn(1'b1, 32'h10, 32'h0BADF00D, 4'h0, 1'b0, 1'b0);
    do_txn(1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 1'b0);

    do_txn(1'b0, 32'h20, 32'h0, 4'h0, 1'b1, 1'b0);
    do_txn(1'b0, 32'h10, 32'h0, 4'h0, 1'b1, 1'b0);
    do_txn(1'b0, 32'h04, 32'h0, 4'h0, 1'b0, 1'b0);

    for (int i = 0; i < 80; i++) begin
      r  = int'($urandom_range(0, 9));
      ra = 32'($urandom_range(0, 63)) << 2;
      if (r == 0) ra = ra | 32'($urandom_range(1, 3));
      if (r == 1) ra = ra | (32'd1 << $urandom_range(8, 31));
      do_txn(1'($urandom), ra, $urandom, 4'($urandom), 1'($urandom), 1'b0);
    end
    do_txn(1'b0, 32'h30, 32'h0, 4'h0, 1'b0, 1'b0);

    do_txn(1'b1, 32'h30, 32'h12345678, 4'hF, 1'b0, 1'b1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort_ack", 32'(ack), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_out", rdata | 32'(err), 32'd0);
    rst_n = 1'b1;
    repeat (W + 3) @(negedge clk);
    do_txn(1'b0, 32'h30, 32'h0, 4'h0, 1'b0, 1'b0);

    for (int i = 0; i < 50 && q.size() > 0; i++) @(negedge clk);
    check("drain", 32'(q.size()), 32'd0);

    d0 = $urandom;
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h40; wdata0 = d0; be0 = 4'hF;
    @(posedge clk);
    #1;
    req0 = 1'b0; we0 = 1'b0; addr0 = 32'h3; wdata0 = ~d0;
    @(negedge clk);
    check("w0_ack", 32'(ack0), 32'd1);
    check("w0_err", 32'(err0), 32'd0);
    check("w0_busy", 32'(busy0), 32'd1);
    @(negedge clk);
    check("w0_ack_gone", 32'(ack0), 32'd0);
    check("w0_idle", 32'(busy0), 32'd0);
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h40;
    @(posedge clk);
    #1;
    req0 = 1'b0;
    @(negedge clk);
    check("w0_rd_ack", 32'(ack0), 32'd1);
    check("w0_rdata", rdata0, d0);
    @(negedge clk);
    req0 = 1'b1; addr0 = 32'h41;
    @(posedge clk);
    #1;
    req0 = 1'b0;
    @(negedge clk);
    check("w0_mis_ack", 32'(ack0), 32'd1);
    check("w0_mis_err", 32'(err0), 32'd1);
    check("w0_mis_rdata", rdata0, 32'd0);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1);
  end

endmodule
